// File: rtl/xdot_vel_chain_if.sv
// Signal bundle between the velocity chain, its link source, the transform-by-vector
// stage and the result consumer. The chain connects through the slave modport.
interface xdot_vel_chain_if #(
  parameter int WIDTH = 32
);
  logic                    start_in;
  logic                    link_valid_in;
  logic                    link_ready_out;
  logic signed [WIDTH-1:0] qd_in;
  logic [3:0]              link_out;

  logic signed [WIDTH-1:0] vec_out_AX;
  logic signed [WIDTH-1:0] vec_out_AY;
  logic signed [WIDTH-1:0] vec_out_AZ;
  logic signed [WIDTH-1:0] vec_out_LX;
  logic signed [WIDTH-1:0] vec_out_LY;
  logic signed [WIDTH-1:0] vec_out_LZ;

  logic signed [WIDTH-1:0] xvec_in_AX;
  logic signed [WIDTH-1:0] xvec_in_AY;
  logic signed [WIDTH-1:0] xvec_in_AZ;
  logic signed [WIDTH-1:0] xvec_in_LX;
  logic signed [WIDTH-1:0] xvec_in_LY;
  logic signed [WIDTH-1:0] xvec_in_LZ;
  logic                    mcross_out;

  logic                    vel_valid_out;
  logic                    vel_ready_in;
  logic signed [WIDTH-1:0] vel_out_AX;
  logic signed [WIDTH-1:0] vel_out_AY;
  logic signed [WIDTH-1:0] vel_out_AZ;
  logic signed [WIDTH-1:0] vel_out_LX;
  logic signed [WIDTH-1:0] vel_out_LY;
  logic signed [WIDTH-1:0] vel_out_LZ;
  logic [3:0]              vel_link_out;

  logic                    busy_out;
  logic                    done_out;

  // Environment side: link source, transform stage and result consumer.
  modport master (
    output start_in, link_valid_in, qd_in,
    output xvec_in_AX, xvec_in_AY, xvec_in_AZ, xvec_in_LX, xvec_in_LY, xvec_in_LZ,
    output vel_ready_in,
    input  link_ready_out, link_out,
    input  vec_out_AX, vec_out_AY, vec_out_AZ, vec_out_LX, vec_out_LY, vec_out_LZ,
    input  mcross_out, vel_valid_out,
    input  vel_out_AX, vel_out_AY, vel_out_AZ, vel_out_LX, vel_out_LY, vel_out_LZ,
    input  vel_link_out, busy_out, done_out
  );

  modport slave (
    input  start_in, link_valid_in, qd_in,
    input  xvec_in_AX, xvec_in_AY, xvec_in_AZ, xvec_in_LX, xvec_in_LY, xvec_in_LZ,
    input  vel_ready_in,
    output link_ready_out, link_out,
    output vec_out_AX, vec_out_AY, vec_out_AZ, vec_out_LX, vec_out_LY, vec_out_LZ,
    output mcross_out, vel_valid_out,
    output vel_out_AX, vel_out_AY, vel_out_AZ, vel_out_LX, vel_out_LY, vel_out_LZ,
    output vel_link_out, busy_out, done_out
  );
endinterface

// File: rtl/xdot_vel_chain.sv
// Forward spatial-velocity chain: each link's velocity is the parent velocity carried
// through that link's transform plus the joint rate on the AZ axis.
module xdot_vel_chain #(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int NUM_LINKS    = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  xdot_vel_chain_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef logic signed [WIDTH-1:0] word_t;

  localparam int          NC        = 6;
  localparam int          AZ        = 2;
  localparam logic [3:0]  LAST_LINK = 4'(NUM_LINKS - 1);

  generate
    if (DECIMAL_BITS < 0 || DECIMAL_BITS >= WIDTH || NUM_LINKS < 1 || NUM_LINKS > 15) begin : g_bad_params
      $error("xdot_vel_chain: illegal WIDTH/DECIMAL_BITS/NUM_LINKS combination");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [3:0] link_q, link_d;
  logic [3:0] vel_link_q, vel_link_d;
  logic       vel_valid_q, vel_valid_d;
  logic       done_q, done_d;
  word_t      vec_q [NC];
  word_t      vec_d [NC];
  word_t      vel_q [NC];
  word_t      vel_d [NC];
  word_t      xvec  [NC];
  word_t      v_new [NC];

  logic link_ready;
  logic accept;
  logic take;

  assign xvec[0] = bus.xvec_in_AX;
  assign xvec[1] = bus.xvec_in_AY;
  assign xvec[2] = bus.xvec_in_AZ;
  assign xvec[3] = bus.xvec_in_LX;
  assign xvec[4] = bus.xvec_in_LY;
  assign xvec[5] = bus.xvec_in_LZ;

  // Joint rate lands on the angular-Z axis; the sum wraps in WIDTH bits by design.
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      v_new[i] = xvec[i];
    end
    v_new[AZ] = xvec[AZ] + bus.qd_in;
  end

  assign link_ready = (state_q == RUN) && (!vel_valid_q || bus.vel_ready_in);
  assign accept     = bus.link_valid_in && link_ready;
  assign take       = vel_valid_q && bus.vel_ready_in;

  always_comb begin
    state_d     = state_q;
    link_d      = link_q;
    vel_link_d  = vel_link_q;
    vel_valid_d = vel_valid_q;
    done_d      = 1'b0;
    vec_d       = vec_q;
    vel_d       = vel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = RUN;
          link_d  = '0;
          for (int i = 0; i < NC; i++) begin
            vec_d[i] = '0;
          end
        end
      end

      RUN: begin
        if (accept) begin
          vec_d       = v_new;
          vel_d       = v_new;
          vel_valid_d = 1'b1;
          vel_link_d  = link_q;
          // The index parks on the last link so upstream keeps a valid selection.
          if (link_q == LAST_LINK) begin
            state_d = DRAIN;
          end else begin
            link_d = link_q + 4'd1;
          end
        end else if (take) begin
          vel_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (take) begin
          vel_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      link_q      <= '0;
      vel_link_q  <= '0;
      vel_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        vec_q[i] <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      link_q      <= link_d;
      vel_link_q  <= vel_link_d;
      vel_valid_q <= vel_valid_d;
      done_q      <= done_d;
      for (int i = 0; i < NC; i++) begin
        vec_q[i] <= vec_d[i];
        vel_q[i] <= vel_d[i];
      end
    end
  end

  assign bus.link_ready_out = link_ready;
  assign bus.link_out       = link_q;
  assign bus.mcross_out     = 1'b0;
  assign bus.vel_valid_out  = vel_valid_q;
  assign bus.vel_link_out   = vel_link_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.done_out       = done_q;

  assign bus.vec_out_AX = vec_q[0];
  assign bus.vec_out_AY = vec_q[1];
  assign bus.vec_out_AZ = vec_q[2];
  assign bus.vec_out_LX = vec_q[3];
  assign bus.vec_out_LY = vec_q[4];
  assign bus.vec_out_LZ = vec_q[5];

  assign bus.vel_out_AX = vel_q[0];
  assign bus.vel_out_AY = vel_q[1];
  assign bus.vel_out_AZ = vel_q[2];
  assign bus.vel_out_LX = vel_q[3];
  assign bus.vel_out_LY = vel_q[4];
  assign bus.vel_out_LZ = vel_q[5];

endmodule

// File: tb/tb_xdot_vel_chain.sv
// Directed bench for xdot_vel_chain: 3 links, Q16.16, transform stage modelled as
// identity unless a vector overrides the transformed parent velocity.
module tb_xdot_vel_chain;

  localparam int W  = 32;
  localparam int NL = 3;

  typedef logic [5:0][W-1:0] comp_t;

  typedef struct packed {
    logic         st;
    logic         ux;
    comp_t        x;
    logic [W-1:0] qd;
    comp_t        ev;
    logic [3:0]   el;
  } vec_t;

  logic  clk     = 1'b0;
  logic  reset_n = 1'b1;
  int    checks  = 0;
  int    errors  = 0;
  logic  use_x   = 1'b0;
  comp_t x_force = '0;
  vec_t  tbl [6];

  xdot_vel_chain_if #(.WIDTH(W)) bus ();

  xdot_vel_chain #(
    .WIDTH        (W),
    .DECIMAL_BITS (16),
    .NUM_LINKS    (NL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.xvec_in_AX = use_x ? x_force[0] : bus.vec_out_AX;
    bus.xvec_in_AY = use_x ? x_force[1] : bus.vec_out_AY;
    bus.xvec_in_AZ = use_x ? x_force[2] : bus.vec_out_AZ;
    bus.xvec_in_LX = use_x ? x_force[3] : bus.vec_out_LX;
    bus.xvec_in_LY = use_x ? x_force[4] : bus.vec_out_LY;
    bus.xvec_in_LZ = use_x ? x_force[5] : bus.vec_out_LZ;
  end

  function automatic comp_t comp6(input logic [W-1:0] ax, ay, az, lx, ly, lz);
    return {lz, ly, lx, az, ay, ax};
  endfunction

  function automatic vec_t mkVec(input logic st, ux, input comp_t x, input logic [W-1:0] qd,
                                 input comp_t ev, input logic [3:0] el);
    vec_t r;
    r.st = st; r.ux = ux; r.x = x; r.qd = qd; r.ev = ev; r.el = el;
    return r;
  endfunction

  function automatic comp_t velNow();
    return {bus.vel_out_LZ, bus.vel_out_LY, bus.vel_out_LX,
            bus.vel_out_AZ, bus.vel_out_AY, bus.vel_out_AX};
  endfunction

  function automatic comp_t vecNow();
    return {bus.vec_out_LZ, bus.vec_out_LY, bus.vec_out_LX,
            bus.vec_out_AZ, bus.vec_out_AY, bus.vec_out_AX};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offer one link and wait (bounded) for the accept edge.
  task automatic applyStimulus(input logic [W-1:0] qd);
    int waitCycles;
    waitCycles       = 0;
    bus.qd_in         = qd;
    bus.link_valid_in = 1'b1;
    while (!bus.link_ready_out && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("link accepted in time", bus.link_ready_out, 1'b1);
    @(posedge clk); #1;
    bus.link_valid_in = 1'b0;
  endtask

  task automatic startPass();
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic finishPass(input logic [W-1:0] lastAz);
    @(posedge clk); #1;
    checkOutput("done pulse", bus.done_out, 1'b1);
    checkOutput("idle busy", bus.busy_out, 1'b0);
    checkOutput("idle vel_valid", bus.vel_valid_out, 1'b0);
    checkOutput("idle link_ready", bus.link_ready_out, 1'b0);
    @(posedge clk); #1;
    checkOutput("done one cycle", bus.done_out, 1'b0);
    checkOutput("idle vec_out_AZ hold", bus.vec_out_AZ, lastAz);
  endtask

  initial begin
    comp_t z, c, e;
    z = '0;

    bus.start_in      = 1'b0;
    bus.link_valid_in = 1'b0;
    bus.qd_in         = '0;
    bus.vel_ready_in  = 1'b1;

    tbl[0] = mkVec(1'b1, 1'b0, z, 32'h0001_0000, comp6(0, 0, 32'h0001_0000, 0, 0, 0), 4'd0);
    tbl[1] = mkVec(1'b0, 1'b0, z, 32'h0002_0000, comp6(0, 0, 32'h0003_0000, 0, 0, 0), 4'd1);
    tbl[2] = mkVec(1'b0, 1'b0, z, 32'h0003_0000, comp6(0, 0, 32'h0006_0000, 0, 0, 0), 4'd2);
    tbl[3] = mkVec(1'b1, 1'b1,
                   comp6(32'h1111_1111, 32'h8000_0000, 32'h7FFF_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF),
                   32'h0002_0000,
                   comp6(32'h1111_1111, 32'h8000_0000, 32'h8001_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF),
                   4'd0);
    tbl[4] = mkVec(1'b0, 1'b0, z, 32'hFFFF_0000,
                   comp6(32'h1111_1111, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF),
                   4'd1);
    tbl[5] = mkVec(1'b0, 1'b0, z, 32'h8000_0000,
                   comp6(32'h1111_1111, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF),
                   4'd2);

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", bus.busy_out, 1'b0);
    checkOutput("reset done", bus.done_out, 1'b0);
    checkOutput("reset vel_valid", bus.vel_valid_out, 1'b0);
    checkOutput("reset link_out", bus.link_out, 4'd0);
    checkOutput("reset vel_link", bus.vel_link_out, 4'd0);
    checkOutput("reset link_ready", bus.link_ready_out, 1'b0);
    checkOutput("mcross tied low", bus.mcross_out, 1'b0);
    checkOutput("reset vel_out_AZ", bus.vel_out_AZ, 32'h0);
    checkOutput("reset vec_out_AZ", bus.vec_out_AZ, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].st) begin
        startPass();
        checkOutput($sformatf("v%0d start link_out", i), bus.link_out, 4'd0);
        checkOutput($sformatf("v%0d start busy", i), bus.busy_out, 1'b1);
        c = vecNow();
        for (int k = 0; k < 6; k++) begin
          checkOutput($sformatf("v%0d start vec_out[%0d]", i, k), c[k], 32'h0);
        end
      end
      use_x   = tbl[i].ux;
      x_force = tbl[i].x;
      applyStimulus(tbl[i].qd);
      use_x   = 1'b0;
      c = velNow();
      e = tbl[i].ev;
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("v%0d vel_out[%0d]", i, k), c[k], e[k]);
      end
      checkOutput($sformatf("v%0d vec_out_AZ", i), bus.vec_out_AZ, e[2]);
      checkOutput($sformatf("v%0d vel_link", i), bus.vel_link_out, tbl[i].el);
      checkOutput($sformatf("v%0d vel_valid", i), bus.vel_valid_out, 1'b1);
      if (tbl[i].el == 4'(NL - 1)) begin
        checkOutput($sformatf("v%0d link_out parked", i), bus.link_out, 4'(NL - 1));
        finishPass(e[2]);
      end else begin
        checkOutput($sformatf("v%0d link_out next", i), bus.link_out, tbl[i].el + 4'd1);
      end
    end

    // Backpressure after link 0, then a stalled final result in DRAIN.
    startPass();
    bus.vel_ready_in = 1'b0;
    applyStimulus(32'h0000_8000);
    checkOutput("bp link0 AZ", bus.vel_out_AZ, 32'h0000_8000);
    bus.link_valid_in = 1'b1;
    bus.qd_in         = 32'h0000_4000;
    for (int cyc = 0; cyc < 5; cyc++) begin
      checkOutput("bp link_ready low", bus.link_ready_out, 1'b0);
      checkOutput("bp vel_out_AZ hold", bus.vel_out_AZ, 32'h0000_8000);
      checkOutput("bp vec_out_AZ hold", bus.vec_out_AZ, 32'h0000_8000);
      checkOutput("bp vel_link hold", bus.vel_link_out, 4'd0);
      checkOutput("bp vel_valid hold", bus.vel_valid_out, 1'b1);
      @(posedge clk); #1;
    end
    bus.vel_ready_in = 1'b1;
    #1;
    checkOutput("bp ready released", bus.link_ready_out, 1'b1);
    @(posedge clk); #1;
    bus.link_valid_in = 1'b0;
    checkOutput("bp link1 vel_link", bus.vel_link_out, 4'd1);
    checkOutput("bp link1 AZ", bus.vel_out_AZ, 32'h0000_C000);
    checkOutput("bp link1 vel_valid", bus.vel_valid_out, 1'b1);
    checkOutput("bp link_out", bus.link_out, 4'd2);
    applyStimulus(32'hFFFF_0000);
    bus.vel_ready_in = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(posedge clk); #1;
      checkOutput("drain stall done", bus.done_out, 1'b0);
      checkOutput("drain stall busy", bus.busy_out, 1'b1);
      checkOutput("drain link_out no wrap", bus.link_out, 4'd2);
      checkOutput("drain stall AZ", bus.vel_out_AZ, 32'hFFFF_C000);
    end
    bus.vel_ready_in = 1'b1;
    finishPass(32'hFFFF_C000);

    // start_in during RUN must be ignored.
    startPass();
    applyStimulus(32'h0005_0000);
    startPass();
    checkOutput("busy start link_out", bus.link_out, 4'd1);
    checkOutput("busy start vec_out_AZ", bus.vec_out_AZ, 32'h0005_0000);
    checkOutput("busy start busy", bus.busy_out, 1'b1);

    // Reset mid-pass after link 1.
    applyStimulus(32'h0001_0000);
    checkOutput("pre-reset AZ", bus.vel_out_AZ, 32'h0006_0000);
    checkOutput("pre-reset vel_link", bus.vel_link_out, 4'd1);
    reset_n = 1'b0;
    #2;
    c = velNow();
    e = vecNow();
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("async reset vel_out[%0d]", k), c[k], 32'h0);
      checkOutput($sformatf("async reset vec_out[%0d]", k), e[k], 32'h0);
    end
    checkOutput("async reset link_out", bus.link_out, 4'd0);
    checkOutput("async reset vel_link", bus.vel_link_out, 4'd0);
    checkOutput("async reset vel_valid", bus.vel_valid_out, 1'b0);
    checkOutput("async reset busy", bus.busy_out, 1'b0);
    checkOutput("async reset done", bus.done_out, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("reset no done", bus.done_out, 1'b0);
    end
    reset_n           = 1'b1;
    bus.link_valid_in = 1'b1;
    bus.qd_in         = 32'h0009_0000;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("post-reset link_ready", bus.link_ready_out, 1'b0);
      checkOutput("post-reset vel_valid", bus.vel_valid_out, 1'b0);
      checkOutput("post-reset done", bus.done_out, 1'b0);
    end
    bus.link_valid_in = 1'b0;
    startPass();
    checkOutput("restart link_out", bus.link_out, 4'd0);
    checkOutput("restart vec_out_AZ", bus.vec_out_AZ, 32'h0);
    applyStimulus(32'h0001_0000);
    checkOutput("restart AZ", bus.vel_out_AZ, 32'h0001_0000);
    checkOutput("restart vel_link", bus.vel_link_out, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
